// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port not granted last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic   i_req_if,
    input  logic   i_req_d,
    input  owner_e i_last,
    output owner_e o_winner
);

    always_comb begin
        o_winner = FETCH;
        if (i_req_if && i_req_d) begin
            o_winner = (i_last == FETCH) ? DATA : FETCH;
        end else if (i_req_d) begin
            o_winner = DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between a fetch port and a data port; one access per
// two cycles (ACCESS presents the address, RESP returns the RAM data).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic [3:0]        ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            r_state;
    owner_e            r_owner;
    owner_e            r_last;
    logic              r_if_gnt;
    logic              r_if_rvalid;
    logic              r_d_gnt;
    logic              r_d_rvalid;
    logic              r_ram_read;
    logic [3:0]        r_ram_write;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    owner_e            w_winner;
    logic              w_any_req;

    assign w_any_req = if_req | d_req;

    rr_arb2 u_rr_arb2 (
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // The RAM-side registers double as the capture registers, so later payload
    // changes on the request ports cannot reach an access already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= FETCH;
            r_last      <= FETCH;
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 4'b0000;
            case (r_state)
                ACCESS: begin
                    r_state     <= RESP;
                    r_if_rvalid <= (r_owner == FETCH);
                    r_d_rvalid  <= (r_owner == DATA);
                end
                default: begin
                    // IDLE and RESP both accept a new winner, giving back-to-back accesses
                    if (w_any_req) begin
                        r_state <= ACCESS;
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        if (w_winner == DATA) begin
                            r_ram_addr  <= d_addr;
                            r_ram_wdata <= d_wdata;
                            r_ram_write <= d_we;
                            r_ram_read  <= (d_we == 4'b0000);
                            r_d_gnt     <= 1'b1;
                        end else begin
                            r_ram_addr  <= if_addr;
                            r_ram_wdata <= '0;
                            r_ram_read  <= 1'b1;
                            r_if_gnt    <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign ram_addr  = r_ram_addr;
    assign ram_read  = r_ram_read;
    assign ram_write = r_ram_write;
    assign ram_wdata = r_ram_wdata;
    assign if_rdata  = r_if_rvalid ? ram_rdata : '0;
    assign d_rdata   = r_d_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: synchronous RAM model, transaction-level reference model,
// directed scenarios followed by randomized requesters.
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [3:0]    d_we = 4'b0000;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_read;
    logic [3:0]    ram_write;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int failures = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int a);
        if (a == 5) return 32'h0050_0093;
        if (a == 8) return 32'h1122_3344;
        return (a * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous RAM seen by the DUT: read data appears the cycle after the address.
    logic [31:0] tb_mem [256];
    initial for (int i = 0; i < 256; i++) tb_mem[i] = mem_init(i);

    always @(posedge clk) begin
        if (ram_read) ram_rdata <= tb_mem[ram_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (ram_write[b]) tb_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Reference model: what each cycle must show, derived from transaction timing.
    typedef struct packed {
        logic        if_gnt;
        logic        d_gnt;
        logic        if_rvalid;
        logic        d_rvalid;
        logic        ram_read;
        logic [3:0]  ram_write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        own_d;
        logic        is_read;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } xact_t;

    logic [31:0] ref_mem [256];
    exp_t  e = '0;
    xact_t cur = '0;
    int    ecnt = 0;
    int    last_cap = -1000;
    logic  last_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        last_cap = -1000;
        last_d   = 1'b0;
        e        = '0;
    endtask

    task automatic model_edge();
        exp_t n;
        logic win_d;
        n = '0;
        ecnt++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (last_cap == ecnt - 1) begin
            n.if_rvalid = !cur.own_d;
            n.d_rvalid  = cur.own_d;
            n.chk_rd    = cur.is_read;
            n.rdata     = ref_mem[cur.addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (cur.we[b]) ref_mem[cur.addr[7:0]][8*b +: 8] = cur.wdata[8*b +: 8];
        end
        if ((ecnt - last_cap >= 2) && (if_req || d_req)) begin
            win_d = (if_req && d_req) ? !last_d : d_req;
            cur.own_d   = win_d;
            cur.addr    = win_d ? d_addr : if_addr;
            cur.we      = win_d ? d_we : 4'b0000;
            cur.wdata   = d_wdata;
            cur.is_read = (cur.we == 4'b0000);
            n.if_gnt    = !win_d;
            n.d_gnt     = win_d;
            n.ram_read  = cur.is_read;
            n.ram_write = cur.we;
            n.addr      = cur.addr;
            n.wdata     = cur.wdata;
            last_cap    = ecnt;
            last_d      = win_d;
        end
        e = n;
    endtask

    task automatic compare();
        chk("if_gnt", 64'(if_gnt), 64'(e.if_gnt));
        chk("d_gnt", 64'(d_gnt), 64'(e.d_gnt));
        chk("if_rvalid", 64'(if_rvalid), 64'(e.if_rvalid));
        chk("d_rvalid", 64'(d_rvalid), 64'(e.d_rvalid));
        chk("ram_read", 64'(ram_read), 64'(e.ram_read));
        chk("ram_write", 64'(ram_write), 64'(e.ram_write));
        if (e.ram_read || e.ram_write != 4'b0000) chk("ram_addr", 64'(ram_addr), 64'(e.addr));
        if (e.ram_write != 4'b0000) chk("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
        if (e.chk_rd && e.if_rvalid) chk("if_rdata", 64'(if_rdata), 64'(e.rdata));
        if (e.chk_rd && e.d_rvalid) chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_if_gnt"}, 64'(if_gnt), 64'd0);
        chk({tag, "_d_gnt"}, 64'(d_gnt), 64'd0);
        chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd0);
        chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
        chk({tag, "_ram_read"}, 64'(ram_read), 64'd0);
        chk({tag, "_ram_write"}, 64'(ram_write), 64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_zero(tag);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    logic [11:0] gseq;
    int          gpos [$];
    logic [31:0] old3;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check_reset_zero("por");
        repeat (2) tick();
        rst_n = 1'b1;

        // Both ports requesting continuously: D, IF, D ... with no idle gap
        if_req = 1'b1; if_addr = 16'd1;
        d_req = 1'b1; d_addr = 16'd2; d_we = 4'b0000;
        gseq = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            gseq = {gseq[9:0], if_gnt, d_gnt};
        end
        chk("alternate_seq", 64'(gseq), 64'(12'b01_00_10_00_01_00));
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();

        // Fetch read of address 5
        if_req = 1'b1; if_addr = 16'd5;
        tick();
        chk("fetch_gnt_c2", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        tick();
        chk("fetch_rvalid_c3", 64'(if_rvalid), 64'd1);
        chk("fetch_rdata_c3", 64'(if_rdata), 64'h0050_0093);
        tick();

        // Byte write to address 8, then read back
        d_req = 1'b1; d_addr = 16'd8; d_we = 4'b0011; d_wdata = 32'hAABB_CCDD;
        tick();
        chk("bytewr_ram_write", 64'(ram_write), 64'h3);
        d_req = 1'b0;
        tick();
        chk("bytewr_ram_write_after", 64'(ram_write), 64'h0);
        tick();
        d_req = 1'b1; d_we = 4'b0000;
        tick();
        d_req = 1'b0;
        tick();
        chk("bytewr_readback", 64'(d_rdata), 64'h1122_CCDD);
        tick();

        // Back-to-back data requests, new one raised in RESP
        d_req = 1'b1; d_addr = 16'd4; d_we = 4'b0000;
        gpos.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (d_gnt) gpos.push_back(i);
            if (i == 0) d_req = 1'b0;
            if (i == 1) begin d_req = 1'b1; d_addr = 16'd6; end
            if (i == 2) d_req = 1'b0;
        end
        chk("b2b_gnt_count", 64'(gpos.size()), 64'd2);
        if (gpos.size() == 2) chk("b2b_gnt_gap", 64'(gpos[1] - gpos[0]), 64'd2);

        // Payload change after capture must not reach the RAM
        d_req = 1'b1; d_addr = 16'd2; d_we = 4'b0000;
        tick();
        d_addr = 16'd9; d_req = 1'b0;
        #1 chk("payload_hold_addr", 64'(ram_addr), 64'd2);
        tick();
        chk("payload_hold_rdata", 64'(d_rdata), 64'(mem_init(2)));
        tick();

        // Reset in the middle of a write access to address 3
        old3 = tb_mem[3];
        d_req = 1'b1; d_addr = 16'd3; d_we = 4'b1111; d_wdata = 32'hCAFE_F00D;
        tick();
        chk("abort_ram_write_before", 64'(ram_write), 64'hF);
        d_req = 1'b0;
        pulse_reset("abort");
        tick();
        chk("abort_no_rvalid", 64'(d_rvalid), 64'd0);
        tick();
        chk("abort_mem3_unchanged", 64'(tb_mem[3]), 64'(old3));
        d_req = 1'b1; d_we = 4'b0000;
        tick();
        chk("abort_then_idle_gnt", 64'(d_gnt), 64'd1);
        d_req = 1'b0;
        tick();
        chk("abort_readback", 64'(d_rdata), 64'(old3));
        tick();

        // Randomized requesters
        for (int c = 0; c < 3000; c++) begin
            if (if_req && e.if_gnt) begin
                if ($urandom_range(2) == 0) if_addr = 16'($urandom_range(255));
                else if_req = 1'b0;
            end else if (!if_req && $urandom_range(1) == 0) begin
                if_req = 1'b1; if_addr = 16'($urandom_range(255));
            end
            if (d_req && e.d_gnt) begin
                if ($urandom_range(2) == 0) begin
                    d_addr = 16'($urandom_range(255));
                    d_we = ($urandom_range(2) == 0) ? 4'b0000 : 4'($urandom_range(15));
                    d_wdata = $urandom;
                end else d_req = 1'b0;
            end else if (!d_req && $urandom_range(1) == 0) begin
                d_req = 1'b1;
                d_addr = 16'($urandom_range(255));
                d_we = ($urandom_range(2) == 0) ? 4'b0000 : 4'($urandom_range(15));
                d_wdata = $urandom;
            end
            if ($urandom_range(199) == 0) pulse_reset("rand_rst");
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== ref_mem[i]) chk("final_mem", 64'(tb_mem[i]), 64'(ref_mem[i]));
        chk("final_mem_sample", 64'(tb_mem[8]), 64'(ref_mem[8]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
